// File: rtl/sr04_pkg.sv
// Shared constants for the HC-SR04 echo emulator: cm-to-us scale, range
// defaults, FSM state codes and the jitter LFSR step.
package sr04_pkg;

    localparam int unsigned US_PER_CM  = 58;
    localparam int unsigned MIN_CM_DEF = 2;
    localparam int unsigned MAX_CM_DEF = 400;

    localparam int unsigned CM_W   = 10;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned SUB_W  = 6;
    localparam int unsigned JIT_W  = 3;
    localparam int unsigned LFSR_W = 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_TRIG_HI = 3'd1;
    localparam logic [2:0] ST_BURST   = 3'd2;
    localparam logic [2:0] ST_ECHO    = 3'd3;
    localparam logic [2:0] ST_HOLDOFF = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_TRIG_HI = ST_TRIG_HI,
        S_BURST   = ST_BURST,
        S_ECHO    = ST_ECHO,
        S_HOLDOFF = ST_HOLDOFF
    } state_e;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;
    localparam logic [LFSR_W-1:0] LFSR_MASK = 8'hB8;

    // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_MASK : '0);
    endfunction

endpackage

// File: rtl/sr04_cm_pulse_timer.sv
// Counts cm x US_PER_CM ticks (plus a small tail) without a multiplier;
// o_done_c strobes on the final tick.
module sr04_cm_pulse_timer
    import sr04_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_tick,
    input  logic             i_start,
    input  logic [CM_W-1:0]  i_cm,
    input  logic [JIT_W-1:0] i_extra,
    output logic             o_done_c
);

    logic             r_run;
    logic [SUB_W-1:0] r_sub;
    logic [CM_W-1:0]  r_cm;
    logic [JIT_W-1:0] r_extra;
    logic             w_cm_wrap;
    logic             w_last_cm;
    logic             w_last_extra;

    assign w_cm_wrap    = r_run & i_tick & (r_cm != '0) & (r_sub == SUB_W'(US_PER_CM - 1));
    assign w_last_cm    = w_cm_wrap & (r_cm == CM_W'(1));
    assign w_last_extra = r_run & i_tick & (r_cm == '0) & (r_extra == JIT_W'(1));
    assign o_done_c     = (w_last_cm & (r_extra == '0)) | w_last_extra;

    // cm loop of 0..57 sub-counts, then the optional extra ticks
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_run   <= 1'b0;
            r_sub   <= '0;
            r_cm    <= '0;
            r_extra <= '0;
        end else if (i_start) begin
            r_run   <= 1'b1;
            r_sub   <= '0;
            r_cm    <= i_cm;
            r_extra <= i_extra;
        end else if (o_done_c) begin
            r_run <= 1'b0;
        end else if (r_run && i_tick) begin
            if (r_cm != '0) begin
                if (w_cm_wrap) begin
                    r_sub <= '0;
                    r_cm  <= r_cm - CM_W'(1);
                end else begin
                    r_sub <= r_sub + SUB_W'(1);
                end
            end else begin
                r_extra <= r_extra - JIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sr04_echo_emulator.sv
// HC-SR04 sensor-side responder: trigger check, burst delay, echo of
// distance x 58 us, holdoff. SR04_EMU_JITTER_EN adds 0..7 us LFSR jitter.
module sr04_echo_emulator
    import sr04_pkg::*;
#(
    parameter int unsigned TRIG_MIN_US   = 10,
    parameter int unsigned TRIG_MAX_US   = 1000,
    parameter int unsigned ECHO_DELAY_US = 250,
    parameter int unsigned MIN_CM        = MIN_CM_DEF,
    parameter int unsigned MAX_CM        = MAX_CM_DEF,
    parameter int unsigned NO_ECHO_US    = 38000,
    parameter int unsigned HOLDOFF_US    = 10000
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iTickUs,
    input  logic             iTrig,
    input  logic [CM_W-1:0]  iDistanceCm,
    input  logic             iObjectPresent,
    output logic             oEcho,
    output logic             oBusy,
    output logic             oTrigErr,
    output logic [CNT_W-1:0] oMeasCnt
);

    logic             r_trig_meta, r_trig_sync, r_trig_prev;
    logic             w_rise, w_fall;
    state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic             r_echo, w_echo_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_trig_err, w_trig_err_nxt;
    logic [CNT_W-1:0] r_meas_cnt, w_meas_cnt_nxt;
    logic [CM_W-1:0]  r_dist_cm, w_dist_cm_nxt;
    logic             r_no_obj, w_no_obj_nxt;
    logic             w_timer_start, w_timer_done;
    logic [JIT_W-1:0] w_extra;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_trig_meta <= 1'b0;
            r_trig_sync <= 1'b0;
            r_trig_prev <= 1'b0;
        end else begin
            r_trig_meta <= iTrig;
            r_trig_sync <= r_trig_meta;
            r_trig_prev <= r_trig_sync;
        end
    end

    assign w_rise    = r_trig_sync & ~r_trig_prev;
    assign w_fall    = ~r_trig_sync & r_trig_prev;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

`ifdef SR04_EMU_JITTER_EN
    logic [LFSR_W-1:0] r_lfsr;

    // Advances exactly when busy rises, i.e. once per accepted trigger
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst)
            r_lfsr <= LFSR_SEED;
        else if (w_busy_nxt && !r_busy)
            r_lfsr <= lfsr_next(r_lfsr);
    end

    assign w_extra = r_lfsr[JIT_W-1:0];
`else
    assign w_extra = '0;
`endif

    sr04_cm_pulse_timer u_cm_timer (
        .i_clk    (iClk),
        .i_rst    (iRst),
        .i_tick   (iTickUs),
        .i_start  (w_timer_start),
        .i_cm     (r_dist_cm),
        .i_extra  (w_extra),
        .o_done_c (w_timer_done)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_echo     <= 1'b0;
            r_busy     <= 1'b0;
            r_trig_err <= 1'b0;
            r_meas_cnt <= '0;
            r_dist_cm  <= '0;
            r_no_obj   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_echo     <= w_echo_nxt;
            r_busy     <= w_busy_nxt;
            r_trig_err <= w_trig_err_nxt;
            r_meas_cnt <= w_meas_cnt_nxt;
            r_dist_cm  <= w_dist_cm_nxt;
            r_no_obj   <= w_no_obj_nxt;
        end
    end

    // A tick landing on the entry edge of TRIG_HI/BURST seeds the new count
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_echo_nxt     = r_echo;
        w_busy_nxt     = r_busy;
        w_trig_err_nxt = 1'b0;
        w_meas_cnt_nxt = r_meas_cnt;
        w_dist_cm_nxt  = r_dist_cm;
        w_no_obj_nxt   = r_no_obj;
        w_timer_start  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = S_TRIG_HI;
                    w_cnt_nxt   = CNT_W'(iTickUs);
                end
            end
            S_TRIG_HI: begin
                if (w_fall) begin
                    if (r_cnt >= CNT_W'(TRIG_MIN_US)) begin
                        w_state_nxt    = S_BURST;
                        w_cnt_nxt      = CNT_W'(iTickUs);
                        w_busy_nxt     = 1'b1;
                        w_meas_cnt_nxt = r_meas_cnt + CNT_W'(1);
                        w_no_obj_nxt   = ~iObjectPresent | (iDistanceCm > CM_W'(MAX_CM));
                        w_dist_cm_nxt  = (iDistanceCm < CM_W'(MIN_CM)) ? CM_W'(MIN_CM) : iDistanceCm;
                    end else begin
                        w_state_nxt    = S_IDLE;
                        w_trig_err_nxt = 1'b1;
                    end
                end else if (iTickUs) begin
                    if (w_cnt_inc > CNT_W'(TRIG_MAX_US)) begin
                        w_state_nxt    = S_IDLE;
                        w_trig_err_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            S_BURST: begin
                if (iTickUs) begin
                    if (w_cnt_inc >= CNT_W'(ECHO_DELAY_US)) begin
                        w_state_nxt   = S_ECHO;
                        w_echo_nxt    = 1'b1;
                        w_cnt_nxt     = '0;
                        w_timer_start = ~r_no_obj;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            S_ECHO: begin
                if (r_no_obj ? (iTickUs && (w_cnt_inc >= CNT_W'(NO_ECHO_US))) : w_timer_done) begin
                    w_state_nxt = S_HOLDOFF;
                    w_echo_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                end else if (r_no_obj && iTickUs) begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_HOLDOFF: begin
                if (iTickUs) begin
                    if (w_cnt_inc >= CNT_W'(HOLDOFF_US)) begin
                        w_state_nxt = S_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign oEcho    = r_echo;
    assign oBusy    = r_busy;
    assign oTrigErr = r_trig_err;
    assign oMeasCnt = r_meas_cnt;

endmodule

// File: tb/tb_sr04_echo_emulator.sv
// Scoreboard bench for sr04_echo_emulator: driver pushes expected events,
// a negedge monitor measures delay/width/holdoff in ticks and pops them.
module tb_sr04_echo_emulator;

    localparam int T_MIN    = 10;
    localparam int T_MAX    = 100;
    localparam int DLY      = 25;
    localparam int NO_ECHO  = 3000;
    localparam int HOLD     = 300;
    localparam int MINC     = 2;
    localparam int MAXC     = 400;
    localparam int SYNC_LAT = 2;
    localparam int K_ERR    = 0;
    localparam int K_MEAS   = 1;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iTickUs;
    logic        iTrig;
    logic [9:0]  iDistanceCm;
    logic        iObjectPresent;
    logic        oEcho;
    logic        oBusy;
    logic        oTrigErr;
    logic [15:0] oMeasCnt;

    sr04_echo_emulator #(
        .TRIG_MIN_US   (T_MIN),
        .TRIG_MAX_US   (T_MAX),
        .ECHO_DELAY_US (DLY),
        .MIN_CM        (MINC),
        .MAX_CM        (MAXC),
        .NO_ECHO_US    (NO_ECHO),
        .HOLDOFF_US    (HOLD)
    ) dut (
        .iClk           (iClk),
        .iRst           (iRst),
        .iTickUs        (iTickUs),
        .iTrig          (iTrig),
        .iDistanceCm    (iDistanceCm),
        .iObjectPresent (iObjectPresent),
        .oEcho          (oEcho),
        .oBusy          (oBusy),
        .oTrigErr       (oTrigErr),
        .oMeasCnt       (oMeasCnt)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        int kind;
        int lat;
        int delay;
        int width;
        bit jit;
        int hold;
        int meas;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    bit   full_tick = 1'b0;
    int   exp_meas = 0;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endfunction

    function automatic void check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d..%0d", name, act, lo, hi);
        end
    endfunction

    // Reference width: clamp/out-of-range rules, 58 us per cm
    function automatic int ref_width(input int d, input bit present);
        if (!present || d > MAXC) return NO_ECHO;
        if (d < MINC) return MINC * 58;
        return d * 58;
    endfunction

    initial begin
        iTickUs = 1'b0;
        forever begin
            @(posedge iClk);
            #1;
            iTickUs = full_tick ? 1'b1 : ($urandom_range(0, 7) != 0);
        end
    end

    // ---------------- monitor ----------------
    int cyc_n = 0, rise_cyc = 0, err_len = 0, d_cnt = 0, w_cnt = 0, h_cnt = 0, stray = 0;
    bit seen_echo = 1'b0, p_busy = 1'b0, p_tick = 1'b0, p_trig = 1'b0;

    function automatic void pop_err();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_trig_err actual=1 expected=0");
        end else begin
            e = sb.pop_front();
            check("event_kind_err", e.kind, K_ERR);
            if (e.kind == K_ERR && e.lat >= 0)
                check("trig_err_latency", cyc_n - rise_cyc, e.lat);
        end
    endfunction

    function automatic void pop_meas();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_echo actual=%0d expected=none", w_cnt);
        end else begin
            e = sb.pop_front();
            check("event_kind_meas", e.kind, K_MEAS);
            if (e.kind == K_MEAS) begin
                check("echo_delay", d_cnt, e.delay);
`ifdef SR04_EMU_JITTER_EN
                if (e.jit) check_range("echo_width", w_cnt, e.width, e.width + 7);
                else       check("echo_width", w_cnt, e.width);
`else
                check("echo_width", w_cnt, e.width);
`endif
                check("holdoff", h_cnt, e.hold);
                check("meas_cnt", int'(oMeasCnt), e.meas);
                check("echo_outside_busy", stray, 0);
            end
        end
        stray = 0;
    endfunction

    always @(negedge iClk) begin
        if (iRst) begin
            err_len   = 0;
            p_busy    = 1'b0;
            p_tick    = 1'b0;
            p_trig    = 1'b0;
            seen_echo = 1'b0;
            stray     = 0;
        end else begin
            cyc_n++;
            if (iTrig && !p_trig) rise_cyc = cyc_n;
            if (oTrigErr) begin
                err_len++;
                if (err_len == 1) pop_err();
            end else if (err_len != 0) begin
                check("trig_err_pulse_len", err_len, 1);
                err_len = 0;
            end
            if (oEcho && !oBusy) stray++;
            if (oBusy && !p_busy) begin
                d_cnt     = p_tick ? 1 : 0;
                w_cnt     = 0;
                h_cnt     = 0;
                seen_echo = 1'b0;
            end
            if (oBusy) begin
                if (oEcho) begin
                    w_cnt += iTickUs ? 1 : 0;
                    seen_echo = 1'b1;
                end else if (!seen_echo) begin
                    d_cnt += iTickUs ? 1 : 0;
                end else begin
                    h_cnt += iTickUs ? 1 : 0;
                end
            end
            if (!oBusy && p_busy) pop_meas();
            p_busy = oBusy;
            p_tick = iTickUs;
            p_trig = iTrig;
        end
    end

    // ---------------- driver ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge iClk);
            #1;
        end
    endtask

    // Ticks every clock around the pulse so its width in ticks equals n
    task automatic pulse(input int n);
        full_tick = 1'b1;
        cyc(3);
        iTrig = 1'b1;
        cyc(n);
        iTrig = 1'b0;
        cyc(4);
        full_tick = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n = 0;
        while ((oBusy || sb.size() != 0) && n < limit) begin
            cyc(1);
            n++;
        end
        if (n >= limit) begin
            checks++;
            failures++;
            $display("FAIL timeout_%s actual=%0d pending expected=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_echo(input bit want, input string name);
        int n = 0;
        while (oEcho != want && n < 40000) begin
            cyc(1);
            n++;
        end
        if (n >= 40000) begin
            checks++;
            failures++;
            $display("FAIL timeout_%s actual=%0b expected=%0b", name, oEcho, want);
        end
    endtask

    task automatic measure(input int d, input bit present, input int n,
                           input int d_after, input bit present_after, input bit poke);
        exp_t e;
        iDistanceCm    = 10'(d);
        iObjectPresent = present;
        exp_meas = (exp_meas + 1) % 65536;
        e = '{kind: K_MEAS, lat: -1, delay: DLY, width: ref_width(d, present),
              jit: (present && d <= MAXC), hold: HOLD, meas: exp_meas};
        sb.push_back(e);
        pulse(n);
        iDistanceCm    = 10'(d_after);
        iObjectPresent = present_after;
        if (poke) begin
            wait_echo(1'b1, "echo_rise");
            pulse(20);
            wait_echo(1'b0, "echo_fall");
            pulse(20);
        end
        wait_done("measure", 40000);
        cyc(5);
    endtask

    task automatic bad_trig(input int n);
        exp_t e;
        e = '{kind: K_ERR, lat: (n > T_MAX) ? (SYNC_LAT + T_MAX + 1) : -1,
              delay: 0, width: 0, jit: 1'b0, hold: 0, meas: 0};
        sb.push_back(e);
        pulse(n);
        wait_done("trig_err", 50);
        cyc(5);
    endtask

    initial begin
        iRst           = 1'b1;
        iTrig          = 1'b0;
        iDistanceCm    = 10'd0;
        iObjectPresent = 1'b1;
        cyc(5);
        check("reset_echo", int'(oEcho), 0);
        check("reset_busy", int'(oBusy), 0);
        check("reset_trig_err", int'(oTrigErr), 0);
        check("reset_meas_cnt", int'(oMeasCnt), 0);
        iRst = 1'b0;
        cyc(5);

        measure(100, 1'b1, T_MIN, 100, 1'b1, 1'b0);
        bad_trig(T_MIN - 1);
        bad_trig(5);
        bad_trig(T_MAX + 1);
        bad_trig(150);
        measure(0, 1'b1, T_MAX, 0, 1'b1, 1'b0);
        measure(401, 1'b1, 12, 401, 1'b1, 1'b0);
        measure(50, 1'b0, 12, 50, 1'b0, 1'b0);
        measure(1, 1'b1, 30, 200, 1'b0, 1'b0);
        measure(20, 1'b1, 15, 20, 1'b1, 1'b1);
        measure(100, 1'b1, 11, 10, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            int  d;
            bit  p;
            int  n;
            d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(401, 1023)) : int'($urandom_range(0, 60));
            p = ($urandom_range(0, 9) != 0);
            n = int'($urandom_range(T_MIN, T_MAX));
            if ($urandom_range(0, 2) == 0)
                bad_trig(($urandom_range(0, 1) == 0) ? int'($urandom_range(1, T_MIN - 1))
                                                    : int'($urandom_range(T_MAX + 1, T_MAX + 30)));
            measure(d, p, n, int'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of an echo
        iDistanceCm    = 10'd40;
        iObjectPresent = 1'b1;
        pulse(12);
        wait_echo(1'b1, "reset_echo_rise");
        cyc(30);
        #2;
        iRst = 1'b1;
        #1;
        check("midreset_echo", int'(oEcho), 0);
        check("midreset_busy", int'(oBusy), 0);
        check("midreset_meas_cnt", int'(oMeasCnt), 0);
        sb.delete();
        exp_meas = 0;
        cyc(3);
        iRst = 1'b0;
        cyc(5);
        measure(30, 1'b1, 10, 30, 1'b1, 1'b0);

        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
